// File: rtl/boutons_pkg.sv
// Shared definitions for the push-button interrupt service master:
// slave register map, service FSM states and button count.
package boutons_pkg;

   // Register map of the button PIO slave
   localparam logic [1:0] ADDR_DATA = 2'd0;
   localparam logic [1:0] ADDR_MASK = 2'd2;
   localparam logic [1:0] ADDR_EDGE = 2'd3;

   // Number of push buttons wired to the PIO
   localparam int N_BTN = 2;

   // Interrupt service sequence
   typedef enum logic [2:0] {
      INIT,
      IDLE,
      RD_EC,
      WAIT_RD,
      CLR_EC,
      PUSH
   } svc_state_t;

   // Zero-extend a per-button bit vector to a full bus word
   function automatic logic [31:0] pad_btn(input logic [N_BTN-1:0] bits);
      return {{(32-N_BTN){1'b0}}, bits};
   endfunction

endpackage

// File: rtl/boutons_irq_master.sv
// Hardware replacement for the push-button interrupt handler: arms the PIO
// interrupt mask after reset, then on each irq reads and clears the
// edge-capture register, hands the captured edges to user logic through a
// valid/ready handshake and keeps one press counter per button.
module boutons_irq_master
   import boutons_pkg::*;
#(
   parameter logic [1:0] IRQ_MASK = 2'b11,
   parameter int         CNT_W    = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             irq,
   input  logic [31:0]      readdata,
   output logic [1:0]       address,
   output logic             chipselect,
   output logic             write_n,
   output logic [31:0]      writedata,
   output logic             event_valid,
   output logic [1:0]       event_data,
   input  logic             event_ready,
   output logic [CNT_W-1:0] press_cnt0,
   output logic [CNT_W-1:0] press_cnt1
);

   svc_state_t        state_reg;
   logic              chipselect_reg;
   logic              write_n_reg;
   logic [1:0]        address_reg;
   logic [31:0]       writedata_reg;
   logic              event_valid_reg;
   logic [N_BTN-1:0]  event_data_reg;
   logic [N_BTN-1:0]  cap_reg;

   // Only the low capture bits of the edge register carry information
   logic              readdata_unused;
   assign readdata_unused = ^readdata[31:N_BTN];

   // Service FSM; every bus and event output is loaded on the edge that
   // enters the corresponding phase, so none of them depends
   // combinationally on irq or readdata.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg       <= INIT;
         chipselect_reg  <= 1'b0;
         write_n_reg     <= 1'b1;
         address_reg     <= ADDR_DATA;
         writedata_reg   <= '0;
         event_valid_reg <= 1'b0;
         event_data_reg  <= '0;
         cap_reg         <= '0;
      end else begin
         case (state_reg)
            INIT: begin
               // One write cycle arming the slave interrupt mask
               chipselect_reg <= 1'b1;
               write_n_reg    <= 1'b0;
               address_reg    <= ADDR_MASK;
               writedata_reg  <= pad_btn(IRQ_MASK);
               state_reg      <= IDLE;
            end
            IDLE: begin
               if (irq) begin
                  // Present the edge-capture read address
                  chipselect_reg <= 1'b1;
                  write_n_reg    <= 1'b1;
                  address_reg    <= ADDR_EDGE;
                  writedata_reg  <= '0;
                  state_reg      <= RD_EC;
               end else begin
                  chipselect_reg <= 1'b0;
                  write_n_reg    <= 1'b1;
                  address_reg    <= ADDR_DATA;
                  writedata_reg  <= '0;
               end
            end
            RD_EC: begin
               // Bus idles while the slave returns its registered read data
               chipselect_reg <= 1'b0;
               write_n_reg    <= 1'b1;
               address_reg    <= ADDR_DATA;
               writedata_reg  <= '0;
               state_reg      <= WAIT_RD;
            end
            WAIT_RD: begin
               cap_reg <= readdata[N_BTN-1:0];
               if (readdata[N_BTN-1:0] == '0) begin
                  // Spurious interrupt: nothing captured, nothing to clear
                  state_reg <= IDLE;
               end else begin
                  // Clear exactly the bits that were read, two cycles after
                  // the read address, to keep the lost-edge window short
                  chipselect_reg <= 1'b1;
                  write_n_reg    <= 1'b0;
                  address_reg    <= ADDR_EDGE;
                  writedata_reg  <= pad_btn(readdata[N_BTN-1:0]);
                  state_reg      <= CLR_EC;
               end
            end
            CLR_EC: begin
               chipselect_reg  <= 1'b0;
               write_n_reg     <= 1'b1;
               address_reg     <= ADDR_DATA;
               writedata_reg   <= '0;
               event_valid_reg <= 1'b1;
               event_data_reg  <= cap_reg;
               state_reg       <= PUSH;
            end
            PUSH: begin
               // irq is deliberately ignored here; further edges wait in the slave
               if (event_ready) begin
                  event_valid_reg <= 1'b0;
                  event_data_reg  <= '0;
                  state_reg       <= IDLE;
               end
            end
            default: begin
               state_reg <= INIT;
            end
         endcase
      end
   end

   // One wrapping press counter per button, bumped once per serviced event
   for (genvar gi = 0; gi < N_BTN; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_reg;

      // Count the button when its bit is set in the event being cleared
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            cnt_reg <= '0;
         end else if (state_reg == CLR_EC && cap_reg[gi]) begin
            cnt_reg <= cnt_reg + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign chipselect  = chipselect_reg;
   assign write_n     = write_n_reg;
   assign address     = address_reg;
   assign writedata   = writedata_reg;
   assign event_valid = event_valid_reg;
   assign event_data  = event_data_reg;
   assign press_cnt0  = g_cnt[0].cnt_reg;
   assign press_cnt1  = g_cnt[1].cnt_reg;

endmodule
